// File: rtl/tdc_core_if.sv
// Measurement/result bundle for tdc_core: start/stop events and delay-line taps in,
// a valid/ready-qualified result record out.
interface tdc_core_if #(
  parameter int NUM_STAGES = 16,
  parameter int COARSE_W   = 16
) ();
  localparam int FINE_W = $clog2(NUM_STAGES + 1);

  logic                  start;
  logic                  stop;
  logic [NUM_STAGES-1:0] tap_code;
  logic                  result_ready;
  logic                  result_valid;
  logic [COARSE_W-1:0]   result_coarse;
  logic [FINE_W-1:0]     result_fine;
  logic                  result_timeout;
  logic                  result_overrun;
  logic                  busy;

  modport slave (
    input  start, stop, tap_code, result_ready,
    output result_valid, result_coarse, result_fine, result_timeout, result_overrun, busy
  );

  modport master (
    output start, stop, tap_code, result_ready,
    input  result_valid, result_coarse, result_fine, result_timeout, result_overrun, busy
  );
endinterface

// File: rtl/tdc_core.sv
// Time-to-digital converter core: a coarse clk-cycle counter between start and stop,
// refined by the popcount of a delay-line thermometer code captured with stop.
module tdc_core #(
  parameter int NUM_STAGES = 16,
  parameter int COARSE_W   = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  tdc_core_if.slave     bus
);
  localparam int FINE_W = $clog2(NUM_STAGES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_ENCODE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [COARSE_W-1:0] CNT_MAX = '1;

  logic [1:0]            state_q,   state_d;
  logic [COARSE_W-1:0]   cnt_q,     cnt_d;
  logic [NUM_STAGES-1:0] tap_q,     tap_d;
  logic [COARSE_W-1:0]   coarse_q,  coarse_d;
  logic [FINE_W-1:0]     fine_q,    fine_d;
  logic                  timeout_q, timeout_d;
  logic                  overrun_q, overrun_d;

  // Counting set bits rather than locating the thermometer edge keeps bubbles harmless.
  function automatic logic [FINE_W-1:0] popcount(input logic [NUM_STAGES-1:0] v);
    logic [FINE_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      n = n + FINE_W'(v[i]);
    end
    return n;
  endfunction

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    tap_d     = tap_q;
    coarse_d  = coarse_q;
    fine_d    = fine_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          overrun_d = 1'b0;
        end
      end
      S_RUN: begin
        if (bus.start) overrun_d = 1'b1;
        if (bus.stop) begin
          state_d   = S_ENCODE;
          tap_d     = bus.tap_code;
          coarse_d  = cnt_q;
          timeout_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = S_HOLD;
          coarse_d  = CNT_MAX;
          fine_d    = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + COARSE_W'(1);
        end
      end
      S_ENCODE: begin
        if (bus.start) overrun_d = 1'b1;
        fine_d  = popcount(tap_q);
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // The handshake cycle ends the measurement, so a start there is simply dropped.
        if (bus.result_ready) state_d = S_IDLE;
        else if (bus.start)   overrun_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the tap capture register is reset too, so a discarded measurement leaves no residue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tap_q     <= '0;
      coarse_q  <= '0;
      fine_q    <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so all registers see the same pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tap_q     <= tap_d;
      coarse_q  <= coarse_d;
      fine_q    <= fine_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.result_valid   = (state_q == S_HOLD);
  assign bus.result_coarse  = coarse_q;
  assign bus.result_fine    = fine_q;
  assign bus.result_timeout = timeout_q;
  assign bus.result_overrun = overrun_q;
  assign bus.busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_tdc_core.sv
// Directed plus randomized measurements of tdc_core (16 taps, 4-bit coarse counter),
// each result predicted from start/stop timing with plain arithmetic.
module tb_tdc_core;
  localparam int NS   = 16;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  tdc_core_if #(.NUM_STAGES(NS), .COARSE_W(CW)) bus ();

  tdc_core #(.NUM_STAGES(NS), .COARSE_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"},   32'(bus.result_valid),   0);
    check({tag, "_coarse"},  32'(bus.result_coarse),  0);
    check({tag, "_fine"},    32'(bus.result_fine),    0);
    check({tag, "_timeout"}, 32'(bus.result_timeout), 0);
    check({tag, "_overrun"}, 32'(bus.result_overrun), 0);
    check({tag, "_busy"},    32'(bus.busy),           0);
  endtask

  // k: RUN cycle (0 = first) carrying stop, or <0 / >MAXC for no stop at all.
  task automatic meas(input int k, input logic [NS-1:0] tap, input int ovr_cyc,
                      input int hold_cyc, input bit hold_start, input bit hs_start,
                      input bit idle_stop);
    bit   to;
    int   exp_coarse, exp_fine, exp_lat, cyc;
    bit   exp_ovr;
    to         = !(k >= 0 && k <= MAXC);
    exp_coarse = to ? MAXC : k;
    exp_fine   = to ? 0 : $countones(tap);
    exp_lat    = to ? MAXC + 1 : k + 2;
    exp_ovr    = (ovr_cyc >= 0 && ovr_cyc < exp_lat);

    bus.start        = 1'b1;
    bus.stop         = idle_stop;
    bus.tap_code     = NS'($urandom);
    bus.result_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("run_busy", 32'(bus.busy), 1);
    check("ovr_clear", 32'(bus.result_overrun), 0);

    cyc = 0;
    while (bus.result_valid !== 1'b1 && cyc < 40) begin
      bus.stop         = (cyc == k);
      bus.tap_code     = (cyc == k) ? tap : NS'($urandom);
      bus.start        = (cyc == ovr_cyc);
      bus.result_ready = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    check("latency", 32'(cyc), 32'(exp_lat));

    for (int i = 0; i < hold_cyc; i++) begin
      bus.result_ready = 1'b0;
      bus.start        = hold_start && (i == 1);
      check("hold_valid",   32'(bus.result_valid),   1);
      check("hold_coarse",  32'(bus.result_coarse),  32'(exp_coarse));
      check("hold_fine",    32'(bus.result_fine),    32'(exp_fine));
      check("hold_timeout", 32'(bus.result_timeout), 32'(to));
      check("hold_overrun", 32'(bus.result_overrun), 32'(exp_ovr));
      @(negedge clk);
      if (hold_start && i == 1) exp_ovr = 1'b1;
    end

    bus.result_ready = 1'b1;
    bus.start        = hs_start;
    check("hs_valid",  32'(bus.result_valid),  1);
    check("hs_coarse", 32'(bus.result_coarse), 32'(exp_coarse));
    check("hs_fine",   32'(bus.result_fine),   32'(exp_fine));
    check("hs_timeout", 32'(bus.result_timeout), 32'(to));
    check("hs_overrun", 32'(bus.result_overrun), 32'(exp_ovr));
    @(negedge clk);
    bus.result_ready = 1'b0;
    bus.start        = 1'b0;
    check("post_valid",   32'(bus.result_valid),   0);
    check("post_busy",    32'(bus.busy),           0);
    check("post_coarse",  32'(bus.result_coarse),  32'(exp_coarse));
    check("post_fine",    32'(bus.result_fine),    32'(exp_fine));
    check("post_overrun", 32'(bus.result_overrun), 32'(exp_ovr));
  endtask

  // After a reset, stop activity alone must never produce a result.
  task automatic quiet_after_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.stop     = 1'b1;
      bus.tap_code = NS'($urandom);
      @(negedge clk);
      check("rst_quiet_valid", 32'(bus.result_valid), 0);
      check("rst_quiet_busy",  32'(bus.busy),         0);
    end
    bus.stop = 1'b0;
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    reset_n          = 1'b0;
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.tap_code     = '0;
    bus.result_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    reset_n = 1'b1;

    // Basic: stop on RUN cycle 4 with eight taps set
    meas(4, 16'h00FF, -1, 1, 1'b0, 1'b0, 1'b0);
    // Bubble code, stop in first RUN cycle
    meas(0, 16'h00F7, -1, 1, 1'b0, 1'b0, 1'b0);
    // Saturation without stop, then stop on the saturating cycle
    meas(-1, 16'hFFFF, -1, 2, 1'b0, 1'b0, 1'b0);
    meas(MAXC, 16'h0FFF, -1, 1, 1'b0, 1'b0, 1'b0);
    // Overrun in RUN and HOLD, long hold, start in the handshake cycle
    meas(6, 16'h003F, 2, 10, 1'b1, 1'b1, 1'b0);
    // Overrun cleared by the next accepted start; start+stop together in IDLE
    meas(5, 16'h1FFF, -1, 1, 1'b0, 1'b0, 1'b1);
    // Start only during ENCODE still flags overrun
    meas(3, 16'h0001, 4, 1, 1'b0, 1'b0, 1'b0);

    // Reset mid-RUN
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check_zero_outputs("rst_run");
    quiet_after_reset();

    // Reset mid-HOLD with non-zero result fields
    bus.start = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    @(negedge clk);
    bus.stop     = 1'b1;
    bus.tap_code = 16'h00FF;
    @(negedge clk);
    bus.stop = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_valid",  32'(bus.result_valid),  1);
    check("pre_rst_coarse", 32'(bus.result_coarse), 1);
    #1 reset_n = 1'b0;
    #1 check_zero_outputs("rst_hold");
    quiet_after_reset();
    meas(2, 16'h7FFF, -1, 1, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 14; n++) begin
      int k;
      k = $urandom_range(0, MAXC + 3);
      if (k > MAXC) k = -1;
      meas(k, NS'($urandom), int'($urandom_range(0, 20)) - 3, $urandom_range(0, 4),
           1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
